data_cal_pipe: RTL and testbench
================================

DATA_CAL_PIPE -- requirements
Module: data_cal_pipe

Interface
REQ-001 SHALL have parameter NIB_W, default 4, meaning nibble/field width in bits (>=2).
REQ-002 SHALL have parameter NIB_N, default 4, meaning number of fields in d (>=2, power of two).
REQ-003 SHALL derive localparam SEL_W = $clog2(NIB_N) and DATA_W = NIB_W*NIB_N.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, request strobe; a request is accepted on a rising edge where in_valid=1.
REQ-007 SHALL have port d, input, DATA_W, data word; field k = d[k*NIB_W +: NIB_W].
REQ-008 SHALL have port sel, input, SEL_W, 0 = load, 1..NIB_N-1 = compute with field sel.
REQ-009 SHALL have port mode, input, 2, compute operation (0 add, 1 abs-diff, 2 max, 3 saturating accumulate).
REQ-010 SHALL have port out, output, NIB_W+1, result.
REQ-011 SHALL have port validout, output, 1, one-cycle result strobe.
REQ-012 SHALL have port nodata, output, 1, one-cycle error strobe for a compute issued before any load.

Function
REQ-013 On an accepted request with sel=0, d SHALL be latched into the data register, the loaded flag set and the accumulator cleared; no validout results.
REQ-014 An accepted request with sel!=0 SHALL use the latched data register, never the live d; changes on d during compute requests SHALL not affect results.
REQ-015 Operands: A = field 0, B = field sel of the data register; a load at edge N SHALL be visible to a compute accepted at edge N+1.
REQ-016 mode 0: out = A+B, zero-extended, no overflow (NIB_W+1 bits).
REQ-017 mode 1: out = |A-B|, zero-extended.
REQ-018 mode 2: out = max(A,B), zero-extended.
REQ-019 mode 3: acc = min(acc+B, 2^(NIB_W+1)-1); out = new acc; acc persists across compute requests until the next load or reset.
REQ-020 Pipeline: stage 1 SHALL register A, B, mode, request type and valid at the accepting edge N; stage 2 SHALL compute and drive out/validout/nodata after edge N+1 (latency 1 cycle after acceptance).
REQ-021 Back-to-back requests SHALL be accepted every cycle with no stall; each compute yields exactly one validout pulse, in request order.
REQ-022 A compute accepted while loaded=0 SHALL produce nodata=1 and validout=0 in its result slot, and out and acc SHALL be unchanged.
REQ-023 out SHALL hold its last value while validout=0.
REQ-024 in_valid=0 cycles SHALL insert bubbles: no validout, no nodata, no state change.

Reset
REQ-025 While rst=0: out=0, validout=0, nodata=0, data register=0, acc=0, loaded=0, stage-1 valid=0, independent of clk.
REQ-026 Assertion of rst mid-operation SHALL discard any in-flight stage-1 request; no validout or nodata SHALL appear for it after release.
REQ-027 After release, the first accepted request SHALL be sampled on the first rising edge with rst=1.

Verification (defaults NIB_W=4, NIB_N=4)
REQ-028 Reset release, then compute sel=2 mode 0 -> nodata=1 for one cycle one cycle later, validout=0, out=0.
REQ-029 Load d=16'h8421, then sel=1,2,3 mode 0 on consecutive cycles -> validout high 3 consecutive cycles, out=3,5,9.
REQ-030 Load 16'h8427; sel=3 mode 1 -> 1; sel=1 mode 1 -> 5; sel=3 mode 2 -> 8; d driven to 16'h0000 during computes -> results unchanged.
REQ-031 Load 16'hFFF0; sel=1 mode 3 four times -> out=15,30,31,31; new load then sel=1 mode 3 -> acc restarts from 0.
REQ-032 in_valid=0 with sel=1 for 3 cycles -> no validout, out holds; rst pulsed low one cycle after a compute accept -> no validout, loaded cleared, next compute gives nodata.

Source files
------------

// File: rtl/data_cal_pipe_if.sv
// Request/result bundle for data_cal_pipe: request strobe, data word, field select, op mode, result.
// Pure wiring, no latency of its own.
// No backpressure signals: the requester may issue every cycle and results are never stalled.
interface data_cal_pipe_if #(
  parameter int NIB_W = 4,
  parameter int NIB_N = 4
);
  localparam int SEL_W  = $clog2(NIB_N);
  localparam int DATA_W = NIB_W * NIB_N;

  logic              in_valid;
  logic [DATA_W-1:0] d;
  logic [SEL_W-1:0]  sel;
  logic [1:0]        mode;
  logic [NIB_W:0]    out;
  logic              validout;
  logic              nodata;

  // Requester side
  modport master (
    output in_valid, d, sel, mode,
    input  out, validout, nodata
  );

  // Pipeline side
  modport slave (
    input  in_valid, d, sel, mode,
    output out, validout, nodata
  );
endinterface

// File: rtl/data_cal_pipe.sv
// Loads a word of NIB_N fields, then computes add/abs-diff/max/sat-accumulate of field 0 vs field sel.
// Latency: result (validout or nodata) one cycle after the accepting edge; loads produce no result.
// Backpressure: none; one request per cycle is always accepted, results emerge in request order.
module data_cal_pipe #(
  parameter int NIB_W = 4,
  parameter int NIB_N = 4
) (
  input  logic          clk,
  input  logic          rst,
  data_cal_pipe_if.slave bus
);
  localparam int SEL_W  = $clog2(NIB_N);
  localparam int DATA_W = NIB_W * NIB_N;

  // Latched data word and "a load has happened" flag
  logic [DATA_W-1:0] data_q;
  logic              loaded_q;

  // Stage-1 registers
  logic              s1_vld;
  logic              s1_ld;
  logic              s1_err;
  logic [NIB_W-1:0]  s1_a;
  logic [NIB_W-1:0]  s1_b;
  logic [1:0]        s1_mode;

  // Saturating accumulator
  logic [NIB_W:0]    acc_q;

  // Stage-2 combinational result
  logic [NIB_W:0]    a_x;
  logic [NIB_W:0]    b_x;
  logic [NIB_W+1:0]  acc_sum;
  logic [NIB_W:0]    res;

  logic              req_ld;
  logic              s1_cmp_ok;

  assign req_ld    = bus.in_valid && (bus.sel == '0);
  assign s1_cmp_ok = s1_vld && !s1_ld && !s1_err;

  // Capture loads into the data register; operands always come from the latched word, never live d
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q   <= '0;
      loaded_q <= 1'b0;
    end else if (req_ld) begin
      data_q   <= bus.d;
      loaded_q <= 1'b1;
    end
  end

  // Stage 1: register operands, mode and request type at the accepting edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld  <= 1'b0;
      s1_ld   <= 1'b0;
      s1_err  <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_mode <= '0;
    end else begin
      s1_vld  <= bus.in_valid;
      s1_ld   <= (bus.sel == '0);
      s1_err  <= !loaded_q;
      s1_a    <= data_q[NIB_W-1:0];
      s1_b    <= data_q[int'(bus.sel)*NIB_W +: NIB_W];
      s1_mode <= bus.mode;
    end
  end

  // Stage 2 datapath: all four operations in parallel, mode picks one
  always_comb begin
    a_x     = {1'b0, s1_a};
    b_x     = {1'b0, s1_b};
    acc_sum = {1'b0, acc_q} + {2'b00, s1_b};
    res     = '0;
    case (s1_mode)
      2'd0: res = a_x + b_x;
      2'd1: res = (s1_a >= s1_b) ? (a_x - b_x) : (b_x - a_x);
      2'd2: res = (s1_a >= s1_b) ? a_x : b_x;
      default: res = acc_sum[NIB_W+1] ? '1 : acc_sum[NIB_W:0];
    endcase
  end

  // Stage 2 outputs: strobes last one cycle, out holds between results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out      <= '0;
      bus.validout <= 1'b0;
      bus.nodata   <= 1'b0;
    end else begin
      bus.validout <= s1_cmp_ok;
      bus.nodata   <= s1_vld && !s1_ld && s1_err;
      if (s1_cmp_ok) begin
        bus.out <= res;
      end
    end
  end

  // Accumulator: a newly accepted load clears it and wins over an older compute finishing this edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (req_ld) begin
      acc_q <= '0;
    end else if (s1_cmp_ok && (s1_mode == 2'd3)) begin
      acc_q <= res;
    end
  end
endmodule

// File: tb/tb_data_cal_pipe.sv
// Directed-vector bench for data_cal_pipe at NIB_W=4, NIB_N=4.
// Each cyc() call presents one request and advances past one rising edge.
// Results checked after an edge belong to the request issued one call earlier.
module tb_data_cal_pipe;
  logic clk;
  logic rst;

  int n_vec;
  int n_bad;

  data_cal_pipe_if #(.NIB_W(4), .NIB_N(4)) bus ();

  data_cal_pipe #(.NIB_W(4), .NIB_N(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one request, let one rising edge take it, then settle 1 time unit past the edge
  task automatic cyc(input logic v, input logic [15:0] dd, input logic [1:0] s, input logic [1:0] m);
    bus.in_valid = v;
    bus.d        = dd;
    bus.sel      = s;
    bus.mode     = m;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input logic v, input logic nd, input logic [4:0] o);
    chk({tag, ".validout"}, 32'(bus.validout), 32'(v));
    chk({tag, ".nodata"},   32'(bus.nodata),   32'(nd));
    chk({tag, ".out"},      32'(bus.out),      32'(o));
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    bus.in_valid = 1'b0;
    bus.d        = '0;
    bus.sel      = '0;
    bus.mode     = '0;
    rst          = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk_res("rst_async", 1'b0, 1'b0, 5'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_res("rst_held", 1'b0, 1'b0, 5'd0);
    rst = 1'b1;

    // Compute before any load -> nodata pulse, out untouched
    cyc(1'b1, 16'h8421, 2'd2, 2'd0);
    chk_res("nolaod_slot0", 1'b0, 1'b0, 5'd0);
    cyc(1'b0, 16'h0000, 2'd0, 2'd0);
    chk_res("noload_res", 1'b0, 1'b1, 5'd0);
    cyc(1'b0, 16'h0000, 2'd0, 2'd0);
    chk_res("noload_after", 1'b0, 1'b0, 5'd0);

    // Load 8421 then back-to-back adds with fields 1,2,3
    cyc(1'b1, 16'h8421, 2'd0, 2'd0);
    cyc(1'b1, 16'h8421, 2'd1, 2'd0);
    chk_res("ld_no_vld", 1'b0, 1'b0, 5'd0);
    cyc(1'b1, 16'h8421, 2'd2, 2'd0);
    chk_res("add_s1", 1'b1, 1'b0, 5'd3);
    cyc(1'b1, 16'h8421, 2'd3, 2'd0);
    chk_res("add_s2", 1'b1, 1'b0, 5'd5);
    cyc(1'b0, 16'h8421, 2'd0, 2'd0);
    chk_res("add_s3", 1'b1, 1'b0, 5'd9);
    cyc(1'b0, 16'h8421, 2'd0, 2'd0);
    chk_res("add_idle", 1'b0, 1'b0, 5'd9);

    // Load 8427, then abs-diff / max with live d forced to zero
    cyc(1'b1, 16'h8427, 2'd0, 2'd0);
    cyc(1'b1, 16'h0000, 2'd3, 2'd1);
    cyc(1'b1, 16'h0000, 2'd1, 2'd1);
    chk_res("absd_s3", 1'b1, 1'b0, 5'd1);
    cyc(1'b1, 16'h0000, 2'd3, 2'd2);
    chk_res("absd_s1", 1'b1, 1'b0, 5'd5);
    cyc(1'b0, 16'h0000, 2'd0, 2'd0);
    chk_res("max_s3", 1'b1, 1'b0, 5'd8);

    // Saturating accumulate on field 1 = 15
    cyc(1'b1, 16'hFFF0, 2'd0, 2'd0);
    cyc(1'b1, 16'h0000, 2'd1, 2'd3);
    cyc(1'b1, 16'h0000, 2'd1, 2'd3);
    chk_res("acc_1", 1'b1, 1'b0, 5'd15);
    cyc(1'b1, 16'h0000, 2'd1, 2'd3);
    chk_res("acc_2", 1'b1, 1'b0, 5'd30);
    cyc(1'b1, 16'h0000, 2'd1, 2'd3);
    chk_res("acc_3", 1'b1, 1'b0, 5'd31);
    // New load (field 1 = 3) clears the accumulator
    cyc(1'b1, 16'h0030, 2'd0, 2'd0);
    chk_res("acc_4", 1'b1, 1'b0, 5'd31);
    cyc(1'b1, 16'h0000, 2'd1, 2'd3);
    chk_res("acc_ld_slot", 1'b0, 1'b0, 5'd31);
    cyc(1'b0, 16'h0000, 2'd1, 2'd0);
    chk_res("acc_restart", 1'b1, 1'b0, 5'd3);

    // Bubbles with sel=1 held: nothing happens, out holds
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 16'h0000, 2'd1, 2'd0);
      chk_res($sformatf("bubble%0d", i), 1'b0, 1'b0, 5'd3);
    end

    // Reset lands while a compute sits in stage 1
    cyc(1'b1, 16'h0000, 2'd1, 2'd0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk_res("midrst_async", 1'b0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b0, 16'h0000, 2'd0, 2'd0);
    chk_res("midrst_flush", 1'b0, 1'b0, 5'd0);
    cyc(1'b1, 16'h0000, 2'd1, 2'd0);
    chk_res("midrst_slot", 1'b0, 1'b0, 5'd0);
    cyc(1'b0, 16'h0000, 2'd0, 2'd0);
    chk_res("midrst_nodata", 1'b0, 1'b1, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
